uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one serial_send UART transmitter between NREQ byte producers.
//  - Round-robin arbitration on a per-byte basis.
//  - Optional message lock keeps the grant on one requester until its LAST byte.
//  - Sequences serial_send: DATA_IN/WE pulse, then waits out BUSY.
//  - Sits between the protocol/debug producers and the serial_send instance.
// PARAMETERS
//  NREQ           2   number of requesters (1..8)
//  START_TIMEOUT  4   cycles to wait for TX_BUSY rise after TX_WE before flagging ERR
// PORTS
//  CLK       in   1        system clock, rising edge
//  RST_N     in   1        asynchronous reset, active low
//  REQ       in   NREQ     per-requester byte valid, level, held until ACK
//  DATA      in   8*NREQ   byte for requester i at DATA[8*i+7:8*i]
//  LAST      in   NREQ     1 = this byte ends the message (releases lock)
//  ACK       out  NREQ     one-cycle pulse: byte of requester i accepted
//  GRANT     out  NREQ     one-hot current owner, 0 when idle/unlocked
//  TX_DATA   out  8        to serial_send DATA_IN, stable from WE until BUSY falls
//  TX_WE     out  1        to serial_send WE, one-cycle pulse
//  TX_BUSY   in   1        from serial_send BUSY
//  ERR       out  1        sticky: TX_BUSY never rose within START_TIMEOUT
// BEHAVIOUR
//  - Reset (RST_N=0, async): state IDLE; ACK=0, GRANT=0, TX_DATA=0, TX_WE=0,
//    ERR=0, lock=0, rr pointer=0 (requester 0 has top priority first).
//  - FSM states: IDLE, LOAD, WAIT_BUSY, WAIT_DONE, HOLD.
//  - IDLE, TX_BUSY=0, |REQ:
//    - Winner = first set REQ at or after rr pointer, wrapping NREQ-1 -> 0.
//    - On the edge: GRANT<=onehot(winner), TX_DATA<=DATA[winner],
//      ACK[winner]<=1, lock<=~LAST[winner], rr pointer<=winner+1 mod NREQ;
//      go to LOAD.
//  - IDLE with TX_BUSY=1: no grant; stay (transmitter not ours to use yet).
//  - LOAD: TX_WE=1 for exactly this cycle; ACK drops; go to WAIT_BUSY.
//  - WAIT_BUSY: TX_BUSY=1 -> WAIT_DONE.
//    - After START_TIMEOUT cycles without TX_BUSY: ERR<=1, lock<=0,
//      GRANT<=0 -> IDLE.
//  - WAIT_DONE: stay while TX_BUSY=1. On TX_BUSY=0:
//    - lock=1 -> HOLD.
//    - else GRANT<=0 -> IDLE.
//  - HOLD: only the owner is served; other REQs are ignored.
//    - REQ[owner]=1: latch as in IDLE (ACK, TX_DATA, lock<=~LAST);
//      rr pointer unchanged -> LOAD.
//    - REQ[owner]=0: lock<=0, GRANT<=0 -> IDLE (abandoned message).
//  - Latency: REQ sampled in cycle T -> ACK and GRANT high in T+1,
//    TX_WE high in T+1. Back-to-back bytes are separated by 1 idle cycle
//    after BUSY falls.
//  - Simultaneous REQs resolve strictly by rr pointer. REQ is never
//    re-sampled between ACK and the end of that byte.
//  - TX_DATA held constant LOAD..WAIT_DONE. Requesters change DATA/REQ only
//    after seeing ACK.
//  - RST_N asserted mid-byte: immediate return to reset values. The
//    serial_send frame in flight is not tracked; the next grant waits for
//    TX_BUSY=0 in IDLE.
//  - NREQ=1: arbiter degenerates to a sequencer; pointer is always 0.
//  - ERR is cleared only by reset.
// TESTING (serial_send with WAIT_DIV=5 as TX model)
//  - Single byte: REQ=01, DATA[7:0]=8'h41, LAST=1 -> ACK[0] 1 cycle, one
//    TX_WE; DATA_OUT frame 0x41 (start, LSB-first, stop); GRANT back to 0.
//  - Contention: REQ=11 held, bytes 0x41/0x42, LAST=11 -> grant order
//    0,1,0,1; four frames alternating 41,42,41,42.
//  - Lock: req0 sends 0x10,0x11,0x12 (LAST on 0x12) with req1 pending 0x55
//    -> frames 10,11,12,55; GRANT stays 01 across all three.
//  - Abandon: req0 sends 0x20 LAST=0, then drops REQ -> HOLD exits to IDLE,
//    GRANT=0, req1's 0xAA served next.
//  - Timeout: TX_BUSY tied 0 -> ERR=1 START_TIMEOUT cycles after TX_WE;
//    FSM idle; next REQ still ACKed.
//  - Reset mid-frame: RST_N low during WAIT_DONE -> all outputs 0 at once;
//    after release, no TX_WE until TX_BUSY=0.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers, the arbiter and the serial_send transmitter.
// The arbiter takes the slave view; producers and the transmitter model take the master view.
interface uart_tx_arbiter_if #(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] data;
  logic [NREQ-1:0]   last;
  logic [NREQ-1:0]   ack;
  logic [NREQ-1:0]   grant;
  logic [7:0]        tx_data;
  logic              tx_we;
  logic              tx_busy;
  logic              err;

  modport slave (
    input  req, data, last, tx_busy,
    output ack, grant, tx_data, tx_we, err
  );

  modport master (
    output req, data, last, tx_busy,
    input  ack, grant, tx_data, tx_we, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one serial_send transmitter between NREQ byte producers.
// Bytes are granted round-robin; a requester whose byte is not LAST keeps the
// grant (HOLD) until its LAST byte or until it abandons the message.
// Each byte is handed over with a one-cycle TX_WE and the arbiter then waits
// for BUSY to rise (bounded by START_TIMEOUT, else sticky ERR) and to fall.
module uart_tx_arbiter #(
  parameter int NREQ          = 2,
  parameter int START_TIMEOUT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_tx_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(START_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(START_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE,
    HOLD
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            lock;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic [CW-1:0]   wait_cnt;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   pick_next_ptr;
  logic [NREQ-1:0] pick_onehot;
  logic [NREQ-1:0] owner_onehot;
  logic            start_grant;
  logic            timeout_hit;

  // Round-robin search: first asserted REQ at or after rr_ptr, wrapping to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_found && bus.req[(int'(rr_ptr) + k) % NREQ]) begin
        pick_found = 1'b1;
        pick_idx   = PW'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end

  assign pick_next_ptr = PW'((int'(pick_idx) + 1) % NREQ);
  assign pick_onehot   = NREQ'(1) << pick_idx;
  assign owner_onehot  = NREQ'(1) << owner;
  assign start_grant   = (state == IDLE) && !bus.tx_busy && pick_found;
  assign timeout_hit   = (state == WAIT_BUSY) && !bus.tx_busy && (wait_cnt == CNT_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic; HOLD serves only the owner, IDLE waits for a quiet transmitter.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (start_grant) state_next = LOAD;
      LOAD:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (bus.tx_busy)      state_next = WAIT_DONE;
        else if (timeout_hit) state_next = IDLE;
      end
      WAIT_DONE: if (!bus.tx_busy) state_next = lock ? HOLD : IDLE;
      HOLD:      state_next = bus.req[owner] ? LOAD : IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Write-enable to serial_send is a pure decode of LOAD, so it lasts exactly one cycle.
  always_comb begin
    bus.tx_we = (state == LOAD);
  end

  // Grant, ack, byte latch, lock, pointer, timeout counter and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ack     <= '0;
      bus.grant   <= '0;
      bus.tx_data <= '0;
      bus.err     <= 1'b0;
      lock        <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      wait_cnt    <= '0;
    end else begin
      bus.ack <= '0;
      case (state)
        IDLE: begin
          if (start_grant) begin
            bus.grant   <= pick_onehot;
            bus.ack     <= pick_onehot;
            bus.tx_data <= bus.data[8*pick_idx +: 8];
            lock        <= ~bus.last[pick_idx];
            owner       <= pick_idx;
            rr_ptr      <= pick_next_ptr;
          end
        end
        LOAD: begin
          wait_cnt <= '0;
        end
        WAIT_BUSY: begin
          if (!bus.tx_busy) begin
            if (wait_cnt == CNT_LAST) begin
              bus.err   <= 1'b1;
              bus.grant <= '0;
              lock      <= 1'b0;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (!bus.tx_busy && !lock) bus.grant <= '0;
        end
        HOLD: begin
          if (bus.req[owner]) begin
            bus.ack     <= owner_onehot;
            bus.tx_data <= bus.data[8*owner +: 8];
            lock        <= ~bus.last[owner];
          end else begin
            bus.grant <= '0;
            lock      <= 1'b0;
          end
        end
        default: begin
          bus.grant <= '0;
          lock      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NREQ=2, START_TIMEOUT=4.
// A small serial_send stand-in (WAIT_DIV=5, 10-bit frame = 50 busy cycles)
// records every byte it accepts and ignores the arbiter's reset.
module tb_uart_tx_arbiter;

  localparam int NREQ         = 2;
  localparam int FRAME_CYCLES = 50;

  logic clk = 1'b0;
  logic rst_n;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(.NREQ(NREQ), .START_TIMEOUT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Transmitter stand-in state.
  logic       model_en = 1'b1;
  int         busy_cnt = 0;
  logic [7:0] frame_byte = 8'h00;
  logic [7:0] sent_q[$];
  int         we_while_busy = 0;
  int         unstable = 0;

  assign bus.tx_busy = (busy_cnt != 0);

  // Transmitter stand-in: accepts a byte on WE when idle, then stays busy for one frame.
  always @(posedge clk) begin
    if (bus.tx_we && busy_cnt != 0) we_while_busy <= we_while_busy + 1;
    if (busy_cnt != 0 && bus.grant != '0 && bus.tx_data !== frame_byte) unstable <= unstable + 1;
    if (model_en && bus.tx_we && busy_cnt == 0) begin
      sent_q.push_back(bus.tx_data);
      frame_byte <= bus.tx_data;
      busy_cnt   <= FRAME_CYCLES;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  // Producer scripts used by apply_stimulus.
  logic [7:0] q_data [NREQ][4];
  logic       q_last [NREQ][4];
  int         q_len  [NREQ];
  int         q_pos  [NREQ];
  int         ack_log[$];
  logic [1:0] grant_log[$];
  int         drops;

  // Hard stop in case something wedges outside the bounded loops.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    assert (obs === exp) else begin
      n_mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("[TB] %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic report_timeout(input string tag);
    n_compared++;
    n_mismatched++;
    $display("[TB] FAIL %s: observed timeout expected completion", tag);
  endtask

  task automatic do_reset();
    bus.req  = '0;
    bus.data = '0;
    bus.last = '0;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic set_byte(input int i, input int k, input logic [7:0] b, input logic l);
    q_data[i][k] = b;
    q_last[i][k] = l;
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int cyc = 0;
    while (bus.grant != '0 || bus.tx_busy) begin
      tick();
      cyc++;
      if (cyc >= max_cycles) begin
        report_timeout(tag);
        break;
      end
    end
  endtask

  // Runs the producer scripts: each requester holds REQ/DATA/LAST until it sees its ACK.
  task automatic apply_stimulus(input string tag, input int max_cycles);
    int         cyc = 0;
    logic [1:0] prev_grant;
    logic       all_done;
    ack_log.delete();
    grant_log.delete();
    sent_q.delete();
    drops = 0;
    for (int i = 0; i < NREQ; i++) q_pos[i] = 0;
    prev_grant = bus.grant;
    forever begin
      for (int i = 0; i < NREQ; i++) begin
        bus.req[i]        = (q_pos[i] < q_len[i]);
        bus.data[8*i +: 8] = (q_pos[i] < q_len[i]) ? q_data[i][q_pos[i]] : 8'h00;
        bus.last[i]       = (q_pos[i] < q_len[i]) ? q_last[i][q_pos[i]] : 1'b0;
      end
      tick();
      cyc++;
      if (bus.grant == '0 && prev_grant != '0) drops++;
      prev_grant = bus.grant;
      for (int i = 0; i < NREQ; i++) begin
        if (bus.ack[i]) begin
          ack_log.push_back(i);
          grant_log.push_back(bus.grant);
          q_pos[i]++;
        end
      end
      all_done = 1'b1;
      for (int i = 0; i < NREQ; i++) if (q_pos[i] < q_len[i]) all_done = 1'b0;
      if (all_done && bus.grant == '0 && !bus.tx_busy) break;
      if (cyc >= max_cycles) begin
        report_timeout(tag);
        break;
      end
    end
    bus.req  = '0;
    bus.last = '0;
  endtask

  task automatic check_sent(input string tag, input int n, input logic [7:0] e0, e1, e2, e3);
    logic [7:0] e [4];
    e = '{e0, e1, e2, e3};
    check_output({tag, "_count"}, sent_q.size(), n);
    for (int k = 0; k < n; k++)
      check_output($sformatf("%s_byte%0d", tag, k),
                   (k < sent_q.size()) ? {24'h0, sent_q[k]} : 32'hxxxxxxxx, {24'h0, e[k]});
  endtask

  task automatic check_order(input string tag, input int n, input int o0, o1, o2, o3);
    int o [4];
    o = '{o0, o1, o2, o3};
    check_output({tag, "_acks"}, ack_log.size(), n);
    for (int k = 0; k < n; k++)
      check_output($sformatf("%s_owner%0d", tag, k),
                   (k < ack_log.size()) ? ack_log[k] : 32'hxxxxxxxx, o[k]);
  endtask

  // Directed sequence of scenarios.
  initial begin
    int cyc;
    int early_we;

    bus.req  = '0;
    bus.data = '0;
    bus.last = '0;
    rst_n    = 1'b0;
    #1;
    check_output("rst_ack",     bus.ack,     0);
    check_output("rst_grant",   bus.grant,   0);
    check_output("rst_tx_data", bus.tx_data, 0);
    check_output("rst_tx_we",   bus.tx_we,   0);
    check_output("rst_err",     bus.err,     0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("[TB] single byte");
    sent_q.delete();
    bus.req  = 2'b01;
    bus.data = {8'h00, 8'h41};
    bus.last = 2'b01;
    tick();
    check_output("single_ack",     bus.ack,     2'b01);
    check_output("single_grant",   bus.grant,   2'b01);
    check_output("single_tx_we",   bus.tx_we,   1);
    check_output("single_tx_data", bus.tx_data, 8'h41);
    bus.req = 2'b00;
    tick();
    check_output("single_ack_drop", bus.ack,   0);
    check_output("single_we_drop",  bus.tx_we, 0);
    check_output("single_grant_hold", bus.grant, 2'b01);
    wait_idle("single_idle", 200);
    check_output("single_grant_end", bus.grant, 0);
    check_sent("single", 1, 8'h41, 8'h00, 8'h00, 8'h00);

    $display("[TB] contention");
    do_reset();
    q_len[0] = 2; set_byte(0, 0, 8'h41, 1'b1); set_byte(0, 1, 8'h41, 1'b1);
    q_len[1] = 2; set_byte(1, 0, 8'h42, 1'b1); set_byte(1, 1, 8'h42, 1'b1);
    apply_stimulus("contention_run", 1000);
    check_order("contention", 4, 0, 1, 0, 1);
    check_sent("contention", 4, 8'h41, 8'h42, 8'h41, 8'h42);
    check_output("contention_drops", drops, 4);

    $display("[TB] message lock");
    do_reset();
    q_len[0] = 3; set_byte(0, 0, 8'h10, 1'b0); set_byte(0, 1, 8'h11, 1'b0); set_byte(0, 2, 8'h12, 1'b1);
    q_len[1] = 1; set_byte(1, 0, 8'h55, 1'b1);
    apply_stimulus("lock_run", 1000);
    check_order("lock", 4, 0, 0, 0, 1);
    check_sent("lock", 4, 8'h10, 8'h11, 8'h12, 8'h55);
    check_output("lock_drops", drops, 2);
    check_output("lock_grant_b2", (grant_log.size() > 2) ? {30'h0, grant_log[2]} : 32'hxxxxxxxx, 2'b01);

    $display("[TB] abandoned message");
    do_reset();
    q_len[0] = 1; set_byte(0, 0, 8'h20, 1'b0);
    q_len[1] = 1; set_byte(1, 0, 8'hAA, 1'b1);
    apply_stimulus("abandon_run", 1000);
    check_order("abandon", 2, 0, 1, 0, 0);
    check_sent("abandon", 2, 8'h20, 8'hAA, 8'h00, 8'h00);
    check_output("abandon_drops", drops, 2);

    $display("[TB] start timeout");
    do_reset();
    sent_q.delete();
    model_en = 1'b0;
    bus.req  = 2'b01;
    bus.data = {8'h00, 8'h33};
    bus.last = 2'b01;
    tick();
    check_output("to_ack",   bus.ack,   2'b01);
    check_output("to_tx_we", bus.tx_we, 1);
    bus.req = 2'b00;
    for (int k = 0; k < 4; k++) tick();
    check_output("to_err_early",   bus.err,   0);
    check_output("to_grant_early", bus.grant, 2'b01);
    tick();
    check_output("to_err_set",  bus.err,   1);
    check_output("to_grant_0",  bus.grant, 0);
    model_en = 1'b1;
    bus.req  = 2'b10;
    bus.data = {8'h77, 8'h00};
    bus.last = 2'b10;
    tick();
    check_output("to_next_ack",  bus.ack,     2'b10);
    check_output("to_next_data", bus.tx_data, 8'h77);
    bus.req = 2'b00;
    wait_idle("to_idle", 200);
    check_output("to_err_sticky", bus.err, 1);
    check_sent("to", 1, 8'h77, 8'h00, 8'h00, 8'h00);

    $display("[TB] reset mid-frame");
    do_reset();
    check_output("rmf_err_cleared", bus.err, 0);
    sent_q.delete();
    bus.req  = 2'b01;
    bus.data = {8'h00, 8'h5A};
    bus.last = 2'b01;
    tick();
    bus.req = 2'b00;
    for (int k = 0; k < 10; k++) tick();
    check_output("rmf_grant_busy", bus.grant, 2'b01);
    rst_n = 1'b0;
    #1;
    check_output("rmf_ack",     bus.ack,     0);
    check_output("rmf_grant",   bus.grant,   0);
    check_output("rmf_tx_data", bus.tx_data, 0);
    check_output("rmf_tx_we",   bus.tx_we,   0);
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    bus.req  = 2'b01;
    bus.data = {8'h00, 8'h66};
    bus.last = 2'b01;
    cyc      = 0;
    early_we = 0;
    while (bus.ack == '0) begin
      tick();
      cyc++;
      if (bus.tx_we && bus.tx_busy) early_we++;
      if (cyc >= 200) begin
        report_timeout("rmf_ack_wait");
        break;
      end
    end
    check_output("rmf_busy_at_ack", bus.tx_busy, 0);
    check_output("rmf_early_we",    early_we,    0);
    bus.req = 2'b00;
    wait_idle("rmf_idle", 200);
    check_sent("rmf", 2, 8'h5A, 8'h66, 8'h00, 8'h00);

    check_output("we_while_busy", we_while_busy, 0);
    check_output("tx_data_stable", unstable, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
